lab2_proc_int_mul_div_unit_vrtl: RTL and testbench

LAB2_PROC_INT_MUL_DIV_UNIT_VRTL -- requirements
Module: lab2_proc_IntMulDivUnitVRTL

---
 rtl/lab2_proc_int_mul_div_unit_vrtl.sv | 186 ++++++++++++++++++
 tb/tb_lab2_proc_int_mul_div_unit_vrtl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_proc_int_mul_div_unit_vrtl.sv
// Iterative integer multiply/divide unit: shift-add multiply and
// restoring divide sharing one accumulator behind a val/rdy interface.
module lab2_proc_int_mul_div_unit_vrtl #(
    parameter int p_nbits      = 32,
    parameter int p_early_term = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_val,
    output logic                 req_rdy,
    input  logic [2*p_nbits+2:0] req_msg,
    output logic                 resp_val,
    input  logic                 resp_rdy,
    output logic [p_nbits-1:0]   resp_msg,
    output logic                 busy
);

    localparam int N  = p_nbits;
    localparam int CW = $clog2(p_nbits) + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] FN_MUL  = 3'd0;
    localparam logic [2:0] FN_MULH = 3'd1;
    localparam logic [2:0] FN_DIV  = 3'd2;
    localparam logic [2:0] FN_DIVU = 3'd3;
    localparam logic [2:0] FN_REM  = 3'd4;
    localparam logic [2:0] FN_REMU = 3'd5;

    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [N-1:0]  MIN_VAL  = {1'b1, {(N-1){1'b0}}};

    logic [1:0]     state_q, state_d;
    logic [2:0]     fn_q, fn_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic           neg_q, neg_d;
    logic           rneg_q, rneg_d;
    logic [N-1:0]   result_q, result_d;

    logic [N-1:0] in_a, in_b, a_mag, b_mag, spec_res;
    logic [2:0]   in_fn;
    logic         in_mul, in_div, in_sgn;
    logic         a_neg, b_neg, in_dz, in_ovf, in_special;

    // Request decode: magnitudes, and results that need no iteration.
    always_comb begin
        in_a   = req_msg[N-1:0];
        in_b   = req_msg[2*N-1:N];
        in_fn  = req_msg[2*N+2:2*N];
        in_mul = (in_fn == FN_MUL) || (in_fn == FN_MULH);
        in_div = (in_fn >= FN_DIV) && (in_fn <= FN_REMU);
        in_sgn = (in_fn == FN_MULH) || (in_fn == FN_DIV)
              || (in_fn == FN_REM);
        a_neg  = in_sgn && in_a[N-1];
        b_neg  = in_sgn && in_b[N-1];
        a_mag  = a_neg ? -in_a : in_a;
        b_mag  = b_neg ? -in_b : in_b;
        in_dz  = in_div && (in_b == '0);
        in_ovf = ((in_fn == FN_DIV) || (in_fn == FN_REM))
              && (in_a == MIN_VAL) && (in_b == '1);
        in_special = !in_mul && (!in_div || in_dz || in_ovf);
        spec_res = '0;
        if (in_dz) begin
            spec_res = ((in_fn == FN_DIV) || (in_fn == FN_DIVU)) ? '1 : in_a;
        end else if (in_ovf) begin
            spec_res = (in_fn == FN_DIV) ? in_a : '0;
        end
    end

    logic [2*N-1:0] mul_sum, mul_prod;
    logic [N-1:0]   mplier_nx;
    logic [N:0]     div_tmp, div_diff;
    logic           div_ge;
    logic [N-1:0]   div_rem, div_quo;
    logic           is_mul_q, calc_last;

    // The remainder is below the divisor, so the borrow of the trial
    // subtraction alone decides the quotient bit.
    always_comb begin
        is_mul_q  = (fn_q == FN_MUL) || (fn_q == FN_MULH);
        mul_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);
        mul_prod  = neg_q ? -mul_sum : mul_sum;
        mplier_nx = mplier_q >> 1;
        div_tmp   = {acc_q[2*N-1:N], acc_q[N-1]};
        div_diff  = div_tmp - {1'b0, mcand_q[N-1:0]};
        div_ge    = !div_diff[N];
        div_rem   = div_ge ? div_diff[N-1:0] : div_tmp[N-1:0];
        div_quo   = {acc_q[N-2:0], div_ge};
        calc_last = (cnt_q == CNT_LAST)
                 || (is_mul_q && (p_early_term != 0) && (mplier_nx == '0));
    end

    always_comb begin
        state_d  = state_q;
        fn_d     = fn_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (req_val) begin
                    fn_d   = in_fn;
                    cnt_d  = '0;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    if (in_special) begin
                        state_d  = DONE;
                        result_d = spec_res;
                    end else begin
                        state_d  = CALC;
                        mcand_d  = {{N{1'b0}}, in_mul ? a_mag : b_mag};
                        acc_d    = in_mul ? '0 : {{N{1'b0}}, a_mag};
                        mplier_d = in_mul ? b_mag : '0;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (is_mul_q) begin
                    acc_d    = mul_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_nx;
                end else begin
                    acc_d = {div_rem, div_quo};
                end
                if (calc_last) begin
                    state_d = DONE;
                    case (fn_q)
                        FN_MUL:  result_d = mul_prod[N-1:0];
                        FN_MULH: result_d = mul_prod[2*N-1:N];
                        FN_DIV,
                        FN_DIVU: result_d = neg_q ? -div_quo : div_quo;
                        default: result_d = rneg_q ? -div_rem : div_rem;
                    endcase
                end
            end
            DONE: begin
                if (resp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            fn_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            fn_q     <= fn_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    // Outputs are gated by reset so they are quiet from the first
    // cycle reset is low, before any edge has cleared the state.
    assign req_rdy  = reset && (state_q == IDLE);
    assign resp_val = reset && (state_q == DONE);
    assign busy     = reset && (state_q != IDLE);
    assign resp_msg = reset ? result_q : '0;

endmodule

// File: tb/tb_lab2_proc_int_mul_div_unit_vrtl.sv
// Bench for the iterative mul/div unit: directed vector table,
// stall and reset sequences, and randomized traffic vs a model.
module tb_lab2_proc_int_mul_div_unit_vrtl;

    logic        clk;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic [66:0] req_msg;
    logic        resp_val;
    logic        resp_rdy;
    logic [31:0] resp_msg;
    logic        busy;

    int checks = 0;
    int errors = 0;

    lab2_proc_int_mul_div_unit_vrtl #(
        .p_nbits      (32),
        .p_early_term (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_msg  (req_msg),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    typedef struct {
        string       name;
        logic [2:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference results straight from the arithmetic definitions.
    function automatic logic [31:0] model(input logic [2:0] fn,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0]        u;
        logic signed [63:0] s;
        longint             sa, sb;
        logic               ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (fn)
            3'd0: begin u = {32'd0, a} * {32'd0, b}; return u[31:0]; end
            3'd1: begin s = sa * sb; return s[63:32]; end
            3'd2: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                s = sa / sb;
                return s[31:0];
            end
            3'd3: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd4: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                s = sa % sb;
                return s[31:0];
            end
            3'd5: return (b == 0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Called at a negedge; returns at the negedge of the first DONE cycle.
    task automatic run_op(input logic [2:0] fn, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output int lat);
        int w;
        w = 0;
        while (!req_rdy && w < 100) begin
            @(negedge clk);
            w++;
        end
        req_msg = {fn, b, a};
        req_val = 1'b1;
        @(posedge clk);
        #1 req_val = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_val && lat < 100);
        res = resp_msg;
    endtask

    vec_t        vecs [19];
    logic [31:0] res;
    int          lat;
    logic [31:0] exp_q [$];
    logic [31:0] held_msg;
    logic        stalled;
    int          seen;

    initial begin
        vecs[0]  = '{"mul_6x7",     3'd0, 32'd6,        32'd7,        32'd42,       4};
        vecs[1]  = '{"mulh_min_2",  3'd1, 32'h8000_0000, 32'd2,       32'hFFFF_FFFF, 3};
        vecs[2]  = '{"div_m7_2",    3'd2, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 33};
        vecs[3]  = '{"rem_m7_2",    3'd4, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 33};
        vecs[4]  = '{"divu_100_7",  3'd3, 32'd100,      32'd7,        32'd14,       33};
        vecs[5]  = '{"remu_100_7",  3'd5, 32'd100,      32'd7,        32'd2,        33};
        vecs[6]  = '{"divu_5_0",    3'd3, 32'd5,        32'd0,        32'hFFFF_FFFF, 1};
        vecs[7]  = '{"remu_5_0",    3'd5, 32'd5,        32'd0,        32'd5,        1};
        vecs[8]  = '{"div_ovf",     3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[9]  = '{"rem_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       1};
        vecs[10] = '{"fn7",         3'd7, 32'd9,        32'd4,        32'd0,        1};
        vecs[11] = '{"fn6",         3'd6, 32'd3,        32'd4,        32'd0,        1};
        vecs[12] = '{"mul_b0",      3'd0, 32'd5,        32'd0,        32'd0,        2};
        vecs[13] = '{"mul_b_msb",   3'd0, 32'd3,        32'h8000_0000, 32'h8000_0000, 33};
        vecs[14] = '{"div_min_2",   3'd2, 32'h8000_0000, 32'd2,       32'hC000_0000, 33};
        vecs[15] = '{"mulh_m1_m1",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,       2};
        vecs[16] = '{"divu_min_m1", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       33};
        vecs[17] = '{"rem_7_m2",    3'd4, 32'd7,        32'hFFFF_FFFE, 32'd1,        33};
        vecs[18] = '{"div_div0",    3'd2, 32'hFFFF_FFF9, 32'd0,       32'hFFFF_FFFF, 1};

        reset    = 1'b0;
        req_val  = 1'b0;
        req_msg  = '0;
        resp_rdy = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_rdy", req_rdy, 0);
        check("rst_resp_val", resp_val, 0);
        check("rst_busy", busy, 0);
        check("rst_resp_msg", resp_msg, 0);
        reset = 1'b1;
        #1;
        check("post_rst_req_rdy", req_rdy, 1);
        check("post_rst_busy", busy, 0);
        @(negedge clk);

        resp_rdy = 1'b1;
        foreach (vecs[i]) begin
            run_op(vecs[i].fn, vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("%s_res", vecs[i].name), res, vecs[i].exp);
            check($sformatf("%s_lat", vecs[i].name), lat, vecs[i].lat);
            @(negedge clk);
            check($sformatf("%s_rdy_after", vecs[i].name), req_rdy, 1);
        end

        // Response stall in DONE with a competing request that must be ignored.
        resp_rdy = 1'b0;
        run_op(3'd0, 32'd6, 32'd7, res, lat);
        check("stall_lat", lat, 4);
        req_msg = {3'd0, 32'd9, 32'd9};
        req_val = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("stall_val_%0d", k), resp_val, 1);
            check($sformatf("stall_msg_%0d", k), resp_msg, 42);
            check($sformatf("stall_rdy_%0d", k), req_rdy, 0);
            @(negedge clk);
        end
        req_val  = 1'b0;
        resp_rdy = 1'b1;
        check("stall_release_val", resp_val, 1);
        @(negedge clk);
        check("stall_after_rdy", req_rdy, 1);
        check("stall_after_val", resp_val, 0);
        repeat (3) @(negedge clk);
        check("stall_no_ghost_busy", busy, 0);

        // Reset in the middle of a divide must drop it silently.
        req_msg = {3'd2, 32'd3, 32'd1000};
        req_val = 1'b1;
        @(posedge clk);
        #1 req_val = 1'b0;
        repeat (9) @(negedge clk);
        check("middiv_busy", busy, 1);
        reset = 1'b0;
        @(negedge clk);
        check("middiv_rst_val", resp_val, 0);
        check("middiv_rst_busy", busy, 0);
        check("middiv_rst_rdy", req_rdy, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("middiv_rel_rdy", req_rdy, 1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (resp_val) seen++;
        end
        check("middiv_no_resp", seen, 0);
        run_op(3'd0, 32'd3, 32'd5, res, lat);
        check("after_rst_mul_res", res, 15);
        check("after_rst_mul_lat", lat, 4);
        @(negedge clk);

        // Random back-to-back traffic with random backpressure.
        stalled  = 1'b0;
        held_msg = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic [2:0]  rf;
            logic [31:0] ra, rb;
            @(negedge clk);
            rf       = 3'($urandom_range(0, 7));
            ra       = rnd_opnd();
            rb       = rnd_opnd();
            req_val  = ($urandom_range(0, 3) != 0);
            req_msg  = {rf, rb, ra};
            resp_rdy = ($urandom_range(0, 2) != 0);
            #1;
            if (stalled) begin
                check("rnd_hold_val", resp_val, 1);
                check("rnd_hold_msg", resp_msg, held_msg);
            end
            if (req_val && req_rdy) begin
                check("rnd_accept_idle",
                      {exp_q.size() != 0, busy, resp_val}, 0);
                exp_q.push_back(model(rf, ra, rb));
            end
            if (resp_val && resp_rdy) begin
                if (exp_q.size() == 0) begin
                    check("rnd_spurious_resp", 1, 0);
                end else begin
                    check("rnd_result", resp_msg, exp_q.pop_front());
                end
            end
            stalled  = resp_val && !resp_rdy;
            held_msg = resp_msg;
        end
        @(negedge clk);
        req_val  = 1'b0;
        resp_rdy = 1'b1;
        for (int w = 0; w < 100 && exp_q.size() != 0; w++) begin
            #1;
            if (resp_val) check("rnd_drain_result", resp_msg, exp_q.pop_front());
            @(negedge clk);
        end
        check("rnd_drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
